// File: rtl/line_buffer_col.sv
// line_buffer_col: streaming line buffer emitting one vertical NUM_LINES-pixel column per accepted pixel.
// Define LINE_BUF_BORDER_EN to also hold dat_vld low for the left border columns (col < NUM_LINES-1).
module line_buffer_col #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int NUM_LINES  = 7,
   parameter int COL_W      = 10,
   parameter int ROW_W      = 10
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            ena,
   input  logic                            sof,
   input  logic [DATA_WIDTH-1:0]           dat_in,
   output logic [NUM_LINES*DATA_WIDTH-1:0] dat_out,
   output logic                            dat_vld,
   output logic [COL_W-1:0]                col_idx,
   output logic [ROW_W-1:0]                row_idx
);
   localparam int NB = NUM_LINES - 1;
   localparam int PW = NB > 1 ? $clog2(NB) : 1;

   logic [DATA_WIDTH-1:0]           mem_q [NB][IMG_WIDTH];
   logic [COL_W-1:0]                col_q, col_d, col_cur, cidx_q;
   logic [ROW_W-1:0]                row_q, row_d, row_cur, ridx_q;
   logic [PW-1:0]                   ptr_q, ptr_d, lsel;
   logic [NUM_LINES*DATA_WIDTH-1:0] out_q, out_d;
   logic                            vld_q, vld_d, wrap;

   assign dat_out = out_q;
   assign dat_vld = vld_q;
   assign col_idx = cidx_q;
   assign row_idx = ridx_q;

   always_comb begin
      col_cur = sof ? '0 : col_q;
      row_cur = sof ? '0 : row_q;
      wrap    = col_cur == COL_W'(IMG_WIDTH - 1);
      col_d   = wrap ? '0 : col_cur + 1'b1;
      row_d   = (wrap && row_cur != '1) ? row_cur + 1'b1 : row_cur;
      ptr_d   = wrap ? (ptr_q == PW'(NB - 1) ? '0 : ptr_q + 1'b1) : ptr_q;
`ifdef LINE_BUF_BORDER_EN
      vld_d   = row_cur >= ROW_W'(NB) && col_cur >= COL_W'(NB);
`else
      vld_d   = row_cur >= ROW_W'(NB);
`endif
      out_d   = '0;
      out_d[DATA_WIDTH-1:0] = dat_in;
      lsel    = '0;
      // tap k reads line (ptr-k) mod NB; tap NB is the oldest line, read before this pixel overwrites it
      for (int k = 1; k < NUM_LINES; k++) begin
         lsel = int'(ptr_q) >= k ? PW'(int'(ptr_q) - k) : PW'(int'(ptr_q) + NB - k);
         out_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[lsel][col_cur];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q  <= '0;
         row_q  <= '0;
         ptr_q  <= '0;
         out_q  <= '0;
         vld_q  <= 1'b0;
         cidx_q <= '0;
         ridx_q <= '0;
      end else begin
         vld_q <= ena && vld_d;
         if (ena) begin
            col_q  <= col_d;
            row_q  <= row_d;
            ptr_q  <= ptr_d;
            out_q  <= out_d;
            cidx_q <= col_cur;
            ridx_q <= row_cur;
         end
      end
   end

   always_ff @(posedge clk)
      if (ena && !rst) mem_q[ptr_q][col_cur] <= dat_in;
endmodule

// File: tb/tb_line_buffer_col.sv
// tb_line_buffer_col: directed stimulus against a frame-level model of column taps (IMG_WIDTH=8, NUM_LINES=3).
module tb_line_buffer_col;
   localparam int DW = 8, W = 8, NL = 3, CW = 3, RW = 4;
   localparam int RMAX = 2**RW - 1;

   logic clk = 1'b0, rst = 1'b1, ena = 1'b0, sof = 1'b0;
   logic [DW-1:0]    din = '0;
   logic [NL*DW-1:0] dat_out;
   logic             dat_vld;
   logic [CW-1:0]    col_idx;
   logic [RW-1:0]    row_idx;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   line_buffer_col #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .NUM_LINES(NL), .COL_W(CW), .ROW_W(RW)) dut (
      .clk(clk), .rst(rst), .ena(ena), .sof(sof), .dat_in(din),
      .dat_out(dat_out), .dat_vld(dat_vld), .col_idx(col_idx), .row_idx(row_idx)
   );

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // frame model: pixels indexed by true row of the current frame
   logic [DW-1:0]    pix [32][W];
   logic [NL*DW-1:0] e_out = '0;
   logic             e_vld = 1'b0;
   int m_col = 0, m_row = 0, c_m = 0, r_m = 0, e_col = 0, e_row = 0;
   bit known = 0, started = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_col = 0; m_row = 0; e_out = '0; e_vld = 0; e_col = 0; e_row = 0;
         known = 1; started = 1;
      end else if (ena) begin
         c_m = sof ? 0 : m_col;
         r_m = sof ? 0 : m_row;
         pix[r_m][c_m] = din;
`ifdef LINE_BUF_BORDER_EN
         e_vld = r_m >= NL-1 && c_m >= NL-1;
`else
         e_vld = r_m >= NL-1;
`endif
         e_col = c_m;
         e_row = r_m > RMAX ? RMAX : r_m;
         if (e_vld) begin
            e_out[DW-1:0] = din;
            for (int k = 1; k < NL; k++) e_out[k*DW +: DW] = pix[r_m-k][c_m];
         end
         known = e_vld;
         m_col = c_m == W-1 ? 0 : c_m + 1;
         m_row = c_m == W-1 ? r_m + 1 : r_m;
      end else e_vld = 0;
   end

   always @(negedge clk) begin
      if (started) begin
         chk("vld", dat_vld, e_vld);
         chk("col_idx", col_idx, e_col);
         chk("row_idx", row_idx, e_row);
         if (known) chk("dat_out", dat_out, e_out);
      end
   end

   task automatic px(bit en, bit s, logic [DW-1:0] v);
      ena = en; sof = s; din = v;
      @(posedge clk); #1;
   endtask

   task automatic pixel(int r, int c, bit s);
      px(1'b1, s, DW'(r*8 + c));
   endtask

   initial begin
      repeat (2) begin
         px(1'b1, 1'b0, 8'hAA);
         chk("rst_dout", dat_out, 0);
         chk("rst_vld", dat_vld, 0);
         chk("rst_col", col_idx, 0);
         chk("rst_row", row_idx, 0);
      end
      rst = 1'b0;
      for (int r = 0; r < 18; r++)
         for (int c = 0; c < W; c++) begin
            pixel(r, c, r == 0 && c == 0);
            if (r < 2) chk("top_vld", dat_vld, 0);
`ifdef LINE_BUF_BORDER_EN
            if (r == 2 && c < 2) chk("bdr_vld", dat_vld, 0);
`else
            if (r == 2 && c == 0) begin
               chk("a20_out", dat_out, 24'h000810);
               chk("a20_vld", dat_vld, 1);
               chk("a20_row", row_idx, 2);
               chk("a20_col", col_idx, 0);
            end
`endif
            if (r == 2 && c == 2) begin
               chk("a22_out", dat_out, 24'h020A12);
               chk("a22_vld", dat_vld, 1);
            end
            if (r == 3 && c == 7) chk("a37_out", dat_out, 24'h0F171F);
            if (r == 16 && c == 0) chk("row_sat", row_idx, RMAX);
         end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < W; c++) begin
            pixel(r, c, r == 0 && c == 0);
            px(1'b0, 1'b1, 8'hEE);
            chk("gap_vld", dat_vld, 0);
         end
      for (int i = 0; i < 29; i++) pixel(i / 8, i % 8, i == 0);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < W; c++) begin
            pixel(r, c, r == 0 && c == 0);
            if (r == 0 && c == 0) begin
               chk("mid_row", row_idx, 0);
               chk("mid_col", col_idx, 0);
            end
            if (r == 2 && c == 5) chk("mid25_out", dat_out, 24'h050D15);
         end
      for (int i = 0; i < 35; i++) pixel(i / 8, i % 8, i == 0);
      rst = 1'b1;
      px(1'b1, 1'b0, 8'h23);
      chk("mrst_dout", dat_out, 0);
      chk("mrst_vld", dat_vld, 0);
      chk("mrst_row", row_idx, 0);
      rst = 1'b0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < W; c++) begin
            pixel(r, c, r == 0 && c == 0);
            if (r == 2 && c == 2) chk("post22_out", dat_out, 24'h020A12);
         end
      px(1'b0, 1'b0, 8'h00);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
